// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types, constants and width helper for the BCD-to-binary
//               converter (reverse double-dabble).
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;

    // A digit at or above this value after a right shift gets corrected
    localparam logic [DIGIT_W-1:0] CORR_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] CORR_VAL    = 4'd3;

    // Largest legal decimal digit; anything above flags an input error
    localparam logic [DIGIT_W-1:0] DIGIT_MAX   = 4'd9;

    // Number of binary bits needed to hold any DIGITS-digit decimal value
    function automatic int bin_width(input int digits);
        return $clog2(10 ** digits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Single-digit correction for reverse double-dabble: subtracts
//               3 from a 4-bit digit when it is 8 or more, else passes through.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // Correction is only applied at >= 8, so the subtraction never wraps
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= CORR_THRESH) begin
            o_digit = i_digit - CORR_VAL;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd2bin.sv
`default_nettype none
// ============================================================================
// Module      : bcd2bin
// Description : Sequential BCD-to-binary converter. A packed BCD word is
//               captured on start, shifted right BIN_W times through a
//               {bcd, bin} register with per-digit -3 correction, and the
//               binary result is presented with a one-cycle done pulse.
//               Words containing a digit above 9 finish at once with err set.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2bin
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 2,
    localparam int BIN_W  = bin_width(DIGITS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] C_LAST_SHIFT = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SR_W-1:0]    r_sreg;
    logic [CNT_W-1:0]   r_count;
    logic [BIN_W-1:0]   r_bin;
    logic               r_err;

    logic               w_bcd_ok;
    logic               w_last;
    logic [SR_W-1:0]    w_shift_raw;
    logic [SR_W-1:0]    w_shifted;

    // Flag any input digit that is not a legal decimal digit
    always_comb begin
        w_bcd_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) begin
                w_bcd_ok = 1'b0;
            end
        end
    end

    // One right shift of the whole register; the binary field needs no fix-up
    assign w_shift_raw             = r_sreg >> 1;
    assign w_shifted[BIN_W-1:0]    = w_shift_raw[BIN_W-1:0];
    assign w_last                  = (r_count == C_LAST_SHIFT);

    // Post-shift correction of every BCD digit in the upper field
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit_adj
            bcd_digit_adj u_adj (
                .i_digit (w_shift_raw[BIN_W + g*DIGIT_W +: DIGIT_W]),
                .o_digit (w_shifted  [BIN_W + g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; illegal digits skip straight to DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_bcd_ok ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shift register, shift counter and held result/error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg  <= '0;
            r_count <= '0;
            r_bin   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sreg  <= {bcd, {BIN_W{1'b0}}};
                        r_count <= '0;
                        r_err   <= ~w_bcd_ok;
                        if (!w_bcd_ok) begin
                            r_bin <= '0;
                        end
                    end
                end
                SHIFT: begin
                    r_sreg  <= w_shifted;
                    r_count <= r_count + C_CNT_ONE;
                    if (w_last) begin
                        r_bin <= w_shifted[BIN_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bin  = r_bin;
    assign err  = r_err;
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

    // A legal input always drains the BCD field completely by the last shift
    a_residue_zero : assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_state == SHIFT && w_last) |-> (w_shifted[SR_W-1:BIN_W] == '0)
    );

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd2bin
// Description : Self-checking bench for bcd2bin at DIGITS=2 and DIGITS=3.
//               Expected results come from a decimal-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd2bin;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        sel3;
    logic        start2, start3;
    logic [7:0]  bcd2;
    logic [11:0] bcd3;
    logic [6:0]  bin2;
    logic [9:0]  bin3;
    logic        busy2, busy3, done2, done3, err2, err3;

    logic [9:0]  obs_bin;
    logic        obs_busy, obs_done, obs_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start2   = go & ~sel3;
    assign start3   = go & sel3;
    assign obs_bin  = sel3 ? bin3 : {3'b000, bin2};
    assign obs_busy = sel3 ? busy3 : busy2;
    assign obs_done = sel3 ? done3 : done2;
    assign obs_err  = sel3 ? err3  : err2;

    bcd2bin #(.DIGITS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .bcd   (bcd2),
        .bin   (bin2),
        .busy  (busy2),
        .done  (done2),
        .err   (err2)
    );

    bcd2bin #(.DIGITS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .bcd   (bcd3),
        .bin   (bin3),
        .busy  (busy3),
        .done  (done3),
        .err   (err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Decimal value of a packed BCD word, or 0 with bad set if a digit exceeds 9
    function automatic void ref_conv(input logic [11:0] v, input int nd,
                                     output int val, output bit bad);
        int mult;
        int d;
        val  = 0;
        bad  = 1'b0;
        mult = 1;
        for (int i = 0; i < nd; i++) begin
            d = int'((v >> (4 * i)) & 12'hF);
            if (d > 9) bad = 1'b1;
            val  = val + d * mult;
            mult = mult * 10;
        end
        if (bad) val = 0;
    endfunction

    // Start a conversion at the current negedge and check the whole handshake
    task automatic run_conv(input bit d3, input logic [11:0] v, input string tag);
        int nd, bw, exp_val, lat;
        bit bad;
        nd = d3 ? 3 : 2;
        bw = d3 ? 10 : 7;
        ref_conv(v, nd, exp_val, bad);
        sel3 = d3;
        if (d3) bcd3 = v; else bcd2 = v[7:0];
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check({tag, " busy_rise"}, 32'(obs_busy), 32'd1);
        lat = 0;
        while (!obs_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), bad ? 32'd0 : 32'(bw));
        check({tag, " bin"},     32'(obs_bin), 32'(exp_val));
        check({tag, " err"},     32'(obs_err), 32'(bad));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(obs_done), 32'd0);
        check({tag, " busy_fall"},      32'(obs_busy), 32'd0);
        check({tag, " bin_held"},       32'(obs_bin),  32'(exp_val));
        check({tag, " err_held"},       32'(obs_err),  32'(bad));
    endtask

    function automatic logic [11:0] rand_bcd(input int nd, input bit wild);
        logic [11:0] v;
        int unsigned d;
        v = '0;
        for (int i = 0; i < nd; i++) begin
            d = wild ? $urandom_range(0, 15) : $urandom_range(0, 9);
            v = v | (12'(d) << (4 * i));
        end
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        logic [11:0] v;

        rst_n = 1'b0;
        go    = 1'b0;
        sel3  = 1'b0;
        bcd2  = '0;
        bcd3  = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset bin2",  32'(bin2),  32'd0);
        check("reset busy2", 32'(busy2), 32'd0);
        check("reset done2", 32'(done2), 32'd0);
        check("reset err2",  32'(err2),  32'd0);
        check("reset bin3",  32'(bin3),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed two-digit cases, back to back
        run_conv(1'b0, 12'h032, "bcd32");
        run_conv(1'b0, 12'h016, "bcd16");
        run_conv(1'b0, 12'h099, "bcd99");
        run_conv(1'b0, 12'h000, "bcd00");
        run_conv(1'b0, 12'h03C, "bcd3C_invalid");
        run_conv(1'b0, 12'h045, "bcd45_after_err");
        run_conv(1'b0, 12'h0A0, "bcdA0_invalid");

        // Start re-pulsed mid-conversion with a new word must be ignored
        sel3 = 1'b0;
        bcd2 = 8'h32;
        go   = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bcd2 = 8'h77;
        go   = 1'b1;
        @(negedge clk);
        go    = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done2) dones++;
            @(negedge clk);
        end
        check("ignored_start done_count", 32'(dones), 32'd1);
        check("ignored_start bin",        32'(bin2),  32'd32);
        check("ignored_start idle",       32'(busy2), 32'd0);

        // Asynchronous reset three cycles into SHIFT
        bcd2 = 8'h32;
        go   = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst busy", 32'(busy2), 32'd0);
        check("async_rst done", 32'(done2), 32'd0);
        check("async_rst bin",  32'(bin2),  32'd0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done2) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done2) dones++;
        end
        check("async_rst no_done", 32'(dones), 32'd0);
        run_conv(1'b0, 12'h021, "bcd21_after_rst");

        // Randomized two-digit conversions, some with illegal digits
        for (int i = 0; i < 16; i++) begin
            v = rand_bcd(2, (i % 4) == 3);
            run_conv(1'b0, v, $sformatf("rand2_%0d_%h", i, v[7:0]));
        end

        // Three-digit instance: boundary values plus random words
        run_conv(1'b1, 12'h999, "bcd999");
        run_conv(1'b1, 12'h000, "bcd000");
        run_conv(1'b1, 12'h100, "bcd100");
        run_conv(1'b1, 12'h9F9, "bcd9F9_invalid");
        for (int i = 0; i < 12; i++) begin
            v = rand_bcd(3, (i % 4) == 2);
            run_conv(1'b1, v, $sformatf("rand3_%0d_%h", i, v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
